// File: rtl/red_pitaya_dac_arb.sv
// red_pitaya_dac_arb: per-channel DAC arbiter with PLL-lock qualification and ramp-to-zero on release.
module red_pitaya_dac_arb #(
  parameter int DW        = 14,
  parameter int RAMP_STEP = 16,
  parameter int LOCK_WAIT = 1024
) (
  input  logic                 dac_clk_i,
  input  logic                 dac_rstn_i,
  input  logic                 pll_locked_i,
  input  logic [1:0]           req_i,
  input  logic                 prio_i,
  input  logic signed [DW-1:0] dat0_i,
  input  logic signed [DW-1:0] dat1_i,
  output logic [1:0]           gnt_o,
  output logic signed [DW-1:0] dac_dat_o,
  output logic                 dac_en_o,
  output logic                 busy_o
);
  localparam logic [1:0] OFF = 2'd0, IDLE = 2'd1, ACTIVE = 2'd2, RAMP = 2'd3;
  localparam int CW = (LOCK_WAIT > 2) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LOCK_WAIT - 1);
  localparam logic signed [DW:0] STEP = (DW+1)'(RAMP_STEP);
  logic [1:0] state, nxt, gnt_n;
  logic [CW-1:0] cnt, cnt_n;
  logic signed [DW-1:0] dat_n;
  // one extra bit so the most negative sample can be negated safely
  logic signed [DW:0] ext, mag, ramped;
  assign ext    = {dac_dat_o[DW-1], dac_dat_o};
  assign mag    = ext[DW] ? -ext : ext;
  assign ramped = ext[DW] ? ext + STEP : ext - STEP;
  always_comb begin
    nxt   = state;
    gnt_n = gnt_o;
    dat_n = dac_dat_o;
    cnt_n = cnt;
    case (state)
      OFF: begin
        gnt_n = '0;
        dat_n = '0;
        cnt_n = pll_locked_i ? cnt + CW'(1) : '0;
        if (pll_locked_i && cnt == LAST) begin
          nxt   = IDLE;
          cnt_n = '0;
        end
      end
      IDLE: begin
        dat_n = '0;
        if (|req_i) begin
          nxt   = ACTIVE;
          gnt_n = (req_i == 2'b11) ? (prio_i ? 2'b10 : 2'b01) : req_i;
        end
      end
      ACTIVE: begin
        if (~|(req_i & gnt_o)) begin
          nxt   = RAMP;
          gnt_n = '0;
        end else
          dat_n = gnt_o[1] ? dat1_i : dat0_i;
      end
      RAMP: begin
        nxt   = (mag <= STEP) ? IDLE : RAMP;
        dat_n = (mag <= STEP) ? '0 : ramped[DW-1:0];
      end
    endcase
    if (state != OFF && !pll_locked_i) begin
      nxt   = OFF;
      cnt_n = '0;
      gnt_n = '0;
      dat_n = '0;
    end
  end
  always_ff @(posedge dac_clk_i or negedge dac_rstn_i)
    if (!dac_rstn_i) begin
      state     <= OFF;
      cnt       <= '0;
      gnt_o     <= '0;
      dac_dat_o <= '0;
      dac_en_o  <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      state     <= nxt;
      cnt       <= cnt_n;
      gnt_o     <= gnt_n;
      dac_dat_o <= dat_n;
      dac_en_o  <= nxt != OFF;
      busy_o    <= nxt == RAMP;
    end
endmodule

// File: tb/tb_red_pitaya_dac_arb.sv
// tb_red_pitaya_dac_arb: directed and randomized stimulus checked against a cycle-level behavioural model.
module tb_red_pitaya_dac_arb;
  localparam int DW = 14, STEP = 16, LW = 1024;
  logic clk = 1'b0, rstn, lock, prio;
  logic [1:0] req, gnt;
  logic signed [DW-1:0] dat0, dat1, dac_dat;
  logic en, busy;
  int checks = 0, failures = 0;
  int m_run, m_owner, m_out;
  bit m_en, m_ramp;

  red_pitaya_dac_arb #(.DW(DW), .RAMP_STEP(STEP), .LOCK_WAIT(LW)) dut (
    .dac_clk_i(clk), .dac_rstn_i(rstn), .pll_locked_i(lock), .req_i(req), .prio_i(prio),
    .dat0_i(dat0), .dat1_i(dat1), .gnt_o(gnt), .dac_dat_o(dac_dat), .dac_en_o(en), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic m_reset();
    m_run = 0; m_owner = -1; m_out = 0; m_en = 0; m_ramp = 0;
  endtask

  // reference: the lock qualifier counts locked cycles up to LW, ownership is an index
  task automatic m_step();
    int mag;
    if (!rstn) m_reset();
    else if (m_en && !lock) m_reset();
    else if (!m_en) begin
      m_run = lock ? m_run + 1 : 0;
      if (m_run == LW) begin m_en = 1; m_run = 0; end
    end else if (m_ramp) begin
      mag = m_out < 0 ? -m_out : m_out;
      if (mag <= STEP) begin m_out = 0; m_ramp = 0; end
      else m_out += m_out < 0 ? STEP : -STEP;
    end else if (m_owner < 0) begin
      if (req != 0) m_owner = (req == 2'b11) ? int'(prio) : (req == 2'b10 ? 1 : 0);
    end else if (!req[m_owner]) begin
      m_owner = -1; m_ramp = 1;
    end else m_out = m_owner == 1 ? int'(dat1) : int'(dat0);
  endtask

  task automatic check_all();
    chk("dat", int'(dac_dat), m_out);
    chk("gnt", int'(gnt), m_owner < 0 ? 0 : (1 << m_owner));
    chk("en", int'(en), int'(m_en));
    chk("busy", int'(busy), int'(m_ramp));
    chk("onehot", int'($countones(gnt) <= 1), 1);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      m_step();
      @(negedge clk);
      check_all();
    end
  endtask

  initial begin
    rstn = 1'b0; lock = 1'b0; prio = 1'b0; req = 2'b00; dat0 = '0; dat1 = '0;
    m_reset();
    #1 check_all();
    tick(3);
    rstn = 1'b1;
    // lock glitch after 500 cycles restarts qualification
    lock = 1'b1; tick(500);
    lock = 1'b0; tick(1);
    lock = 1'b1; tick(LW + 4);
    // single grant, latency, sample tracking, ramp from -77
    req = 2'b01; dat0 = 14'sd1234; tick(3);
    dat0 = -14'sd77; tick(2);
    req = 2'b00; tick(10);
    // simultaneous request, prio 1, ramp from 1000, request during ramp
    dat1 = 14'sd1000; prio = 1'b1; req = 2'b11; tick(4);
    req = 2'b01; tick(2);
    req = 2'b11; tick(66);
    req = 2'b00; tick(70);
    // simultaneous, prio 0, no preemption, full-scale negative ramp
    dat0 = -14'sd8192; prio = 1'b0; req = 2'b11; tick(5);
    req = 2'b10; dat1 = 14'sd5000; tick(516);
    // lock loss in ACTIVE at 5000
    tick(3);
    lock = 1'b0; tick(1);
    lock = 1'b1; req = 2'b00; tick(LW + 4);
    // lock loss in RAMP
    req = 2'b01; dat0 = 14'sd5000; tick(3);
    req = 2'b00; tick(3);
    lock = 1'b0; tick(1);
    lock = 1'b1; tick(LW + 4);
    // async reset mid-ACTIVE, checked before any clock edge
    req = 2'b01; dat0 = 14'sd3000; tick(4);
    #2 rstn = 1'b0;
    #1 m_reset(); check_all();
    tick(2);
    rstn = 1'b1; req = 2'b00; tick(LW + 4);
    // randomized traffic with rare lock drops
    for (int i = 0; i < 30000; i++) begin
      if ($urandom_range(0, 29) == 0) req[0] = ~req[0];
      if ($urandom_range(0, 29) == 0) req[1] = ~req[1];
      prio = 1'($urandom);
      dat0 = DW'($urandom);
      dat1 = ($urandom_range(0, 9) == 0) ? -14'sd8192 : DW'($urandom);
      lock = $urandom_range(0, 7999) != 0;
      tick(1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
